// File: rtl/input_conditioner.sv
// Input conditioner: two-flop synchronizers and per-channel debouncers for mode/pause
// switches and the play button. Accepted presses raise sticky event/overrun flags.
`default_nettype none

module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch_mode0,
  input  logic       switch_mode1,
  input  logic       switch_pause,
  input  logic       play_btn,
  input  logic       evt_ack,
  output logic [1:0] mode,
  output logic       pause,
  output logic       play_level,
  output logic       play_event,
  output logic       overrun
);

  localparam int            CW        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  // Channel order {play_btn, pause, mode1, mode0}; play_btn idles high.
  localparam logic [3:0]    RST_LEVEL = 4'b1000;

  logic [3:0]    raw_w;
  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  logic [3:0]    acc_q;
  logic [3:0]    acc_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic          press_w;
  logic          play_event_q;
  logic          play_event_d;
  logic          overrun_q;
  logic          overrun_d;

  assign raw_w = {play_btn, switch_pause, switch_mode1, switch_mode0};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_d[i] = acc_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != acc_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          acc_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // A press is the accepted play level falling; a new press beats a same-cycle ack.
  always_comb begin
    press_w      = acc_q[3] & ~acc_d[3];
    play_event_d = press_w | (play_event_q & ~evt_ack);
    overrun_d    = ~evt_ack & (overrun_q | (press_w & play_event_q));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q      <= RST_LEVEL;
      sync2_q      <= RST_LEVEL;
      acc_q        <= RST_LEVEL;
      play_event_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= raw_w;
      sync2_q      <= sync1_q;
      acc_q        <= acc_d;
      play_event_q <= play_event_d;
      overrun_q    <= overrun_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign mode       = acc_q[1:0];
  assign pause      = acc_q[2];
  assign play_level = acc_q[3];
  assign play_event = play_event_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire
